// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and defaults for the two-master SDRAM
//               round-robin arbiter and its read-tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

   localparam int c_DEF_ADDR_W      = 25;
   localparam int c_DEF_DATA_W      = 16;
   localparam int c_DEF_MAX_PENDING = 8;

   // Identifies which master owns a grant or an outstanding read
   typedef logic grant_id_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   // Sole requester wins; on contention the master that did not win last time wins
   function automatic grant_id_t pick_winner(input logic i_req0,
                                             input logic i_req1,
                                             input grant_id_t i_last);
      if (i_req0 && i_req1) begin
         return ~i_last;
      end else if (i_req0) begin
         return 1'b0;
      end else begin
         return 1'b1;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_tag_fifo
// Description : Small synchronous FIFO holding the owner tag of every
//               outstanding read. Simultaneous push and pop keep the count
//               unchanged; a pop on an empty FIFO is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_tag_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int                  c_PTR_W    = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]    c_FULL_CNT = (c_PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_do_pop;
   logic               w_do_push;

   // A push at full is only taken when a pop frees the slot in the same cycle
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   assign o_full  = (r_count == c_FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally at power-of-2 depth
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + (c_PTR_W+1)'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - (c_PTR_W+1)'(1);
         end
      end
   end

   // Tag storage; contents are meaningless until written so no reset is needed
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sdram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rr_arbiter
// Description : Two-master round-robin arbiter in front of the single
//               Avalon-MM port of the SDRAM controller. One transfer per
//               grant; read owners are queued so readdatavalid is routed
//               back to the master that issued the read.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_rr_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W      = c_DEF_ADDR_W,
   parameter int DATA_W      = c_DEF_DATA_W,
   parameter int MAX_PENDING = c_DEF_MAX_PENDING
) (
   input  logic                          clk,
   input  logic                          reset_n,
   // master 0 : HPS lightweight bridge path
   input  logic [ADDR_W-1:0]             m0_address,
   input  logic                          m0_read,
   input  logic                          m0_write,
   input  logic [DATA_W-1:0]             m0_writedata,
   input  logic [DATA_W/8-1:0]           m0_byteenable,
   output logic                          m0_waitrequest,
   output logic [DATA_W-1:0]             m0_readdata,
   output logic                          m0_readdatavalid,
   // master 1 : min/max scan master
   input  logic [ADDR_W-1:0]             m1_address,
   input  logic                          m1_read,
   input  logic                          m1_write,
   input  logic [DATA_W-1:0]             m1_writedata,
   input  logic [DATA_W/8-1:0]           m1_byteenable,
   output logic                          m1_waitrequest,
   output logic [DATA_W-1:0]             m1_readdata,
   output logic                          m1_readdatavalid,
   // SDRAM controller slave
   output logic [ADDR_W-1:0]             s_address,
   output logic                          s_read,
   output logic                          s_write,
   output logic [DATA_W-1:0]             s_writedata,
   output logic [DATA_W/8-1:0]           s_byteenable,
   input  logic                          s_waitrequest,
   input  logic [DATA_W-1:0]             s_readdata,
   input  logic                          s_readdatavalid,
   // debug
   output logic [1:0]                    state_out,
   output logic [$clog2(MAX_PENDING):0]  pending_out,
   output logic                          err_out
);

   arb_state_t r_state;
   arb_state_t w_state_nxt;
   grant_id_t  r_grant_id;
   grant_id_t  w_grant_nxt;
   grant_id_t  r_last_grant;
   grant_id_t  w_last_nxt;
   logic       r_err;

   logic       w_req0;
   logic       w_req1;
   logic       w_sel_read;
   logic       w_sel_write;
   logic       w_sel_rd_only;
   logic       w_s_read;
   logic       w_s_write;
   logic       w_read_block;
   logic       w_accept;
   logic       w_wait_g;

   logic       w_fifo_full;
   logic       w_fifo_empty;
   grant_id_t  w_fifo_head;
   logic       w_push;

   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;

   // Request strobes of the currently granted master; write wins over read
   assign w_sel_read    = r_grant_id ? m1_read  : m0_read;
   assign w_sel_write   = r_grant_id ? m1_write : m0_write;
   assign w_sel_rd_only = w_sel_read & ~w_sel_write;

   // Slave-side address/data mux follows the registered grant
   assign s_address    = r_grant_id ? m1_address    : m0_address;
   assign s_writedata  = r_grant_id ? m1_writedata  : m0_writedata;
   assign s_byteenable = r_grant_id ? m1_byteenable : m0_byteenable;
   assign s_read       = w_s_read;
   assign s_write      = w_s_write;

   // Next-state, strobe gating and waitrequest generation
   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant_id;
      w_last_nxt     = r_last_grant;
      w_s_read       = 1'b0;
      w_s_write      = 1'b0;
      w_read_block   = 1'b0;
      w_accept       = 1'b0;
      w_wait_g       = 1'b1;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (w_req0 || w_req1) begin
               w_grant_nxt = pick_winner(w_req0, w_req1, r_last_grant);
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // A read cannot be issued while every tag slot is in use
            w_read_block = w_fifo_full & w_sel_rd_only;
            w_s_write    = w_sel_write;
            w_s_read     = w_sel_rd_only & ~w_fifo_full;
            w_wait_g     = s_waitrequest | w_read_block;
            if (r_grant_id == 1'b0) begin
               m0_waitrequest = w_wait_g;
            end else begin
               m1_waitrequest = w_wait_g;
            end
            w_accept = (w_s_read | w_s_write) & ~s_waitrequest;
            if (w_accept) begin
               w_last_nxt  = r_grant_id;
               w_state_nxt = ST_IDLE;
            end else if (!(w_sel_read || w_sel_write)) begin
               // Granted master withdrew; give up the grant without a transfer
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Arbiter state, grant history and sticky orphan-data flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_grant_id   <= 1'b0;
         r_last_grant <= 1'b1;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant_id   <= w_grant_nxt;
         r_last_grant <= w_last_nxt;
         if (s_readdatavalid && w_fifo_empty) begin
            r_err <= 1'b1;
         end
      end
   end

   assign w_push = w_accept & w_s_read;

   arb_tag_fifo #(
      .WIDTH (1),
      .DEPTH (MAX_PENDING)
   ) u_tag_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_push),
      .i_push_data (r_grant_id),
      .i_pop       (s_readdatavalid),
      .o_head      (w_fifo_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (pending_out)
   );

   // Read data goes to everyone; the head tag decides who sees it as valid
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = s_readdatavalid & ~w_fifo_empty & (w_fifo_head == 1'b0);
   assign m1_readdatavalid = s_readdatavalid & ~w_fifo_empty & (w_fifo_head == 1'b1);

   assign state_out = {(r_state == ST_GRANT), (r_state == ST_GRANT) & r_grant_id};
   assign err_out   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_rr_arbiter
// Description : Directed self-checking bench for sdram_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_rr_arbiter;

   localparam int ADDR_W      = 25;
   localparam int DATA_W      = 16;
   localparam int MAX_PENDING = 8;

   logic              clk;
   logic              reset_n;
   logic [ADDR_W-1:0] m0_address, m1_address, s_address;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
   logic [1:0]        m0_byteenable, m1_byteenable, s_byteenable;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic              s_read, s_write, s_waitrequest, s_readdatavalid;
   logic [1:0]        state_out;
   logic [3:0]        pending_out;
   logic              err_out;

   int tests_run    = 0;
   int tests_failed = 0;

   sdram_rr_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .MAX_PENDING (MAX_PENDING)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_byteenable    (m0_byteenable),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_byteenable    (m1_byteenable),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .s_address        (s_address),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_waitrequest    (s_waitrequest),
      .s_readdata       (s_readdata),
      .s_readdatavalid  (s_readdatavalid),
      .state_out        (state_out),
      .pending_out      (pending_out),
      .err_out          (err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
      m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
      s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
   endtask

   task automatic apply_reset();
      reset_n = 0;
      step();
      reset_n = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      apply_reset();
      #1;
      tests_run++; if (state_out !== 2'b00) begin tests_failed++; $display("FAIL reset_state: got %b want 00", state_out); end
      tests_run++; if (pending_out !== 4'd0) begin tests_failed++; $display("FAIL reset_pending: got %0d want 0", pending_out); end
      tests_run++; if (err_out !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err_out); end
      tests_run++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin tests_failed++; $display("FAIL reset_wait: got %b want 11", {m0_waitrequest, m1_waitrequest}); end
      tests_run++; if ({s_read, s_write} !== 2'b00) begin tests_failed++; $display("FAIL reset_strobes: got %b want 00", {s_read, s_write}); end
      tests_run++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin tests_failed++; $display("FAIL reset_rdv: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
   endtask

   task automatic test_single_read();
      idle_inputs();
      m0_address = 25'h10; m0_read = 1; s_waitrequest = 1;
      #1;
      tests_run++; if (m0_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL t1_idle_wait: got %b want 1", m0_waitrequest); end
      step();
      #1;
      tests_run++; if (state_out !== 2'b10) begin tests_failed++; $display("FAIL t1_grant: got %b want 10", state_out); end
      tests_run++; if ({s_read, m0_waitrequest, m1_waitrequest} !== 3'b111) begin tests_failed++; $display("FAIL t1_wait1: got %b want 111", {s_read, m0_waitrequest, m1_waitrequest}); end
      step();
      #1;
      tests_run++; if (m0_waitrequest !== 1'b1) begin tests_failed++; $display("FAIL t1_wait2: got %b want 1", m0_waitrequest); end
      step();
      s_waitrequest = 0;
      #1;
      tests_run++; if ({s_read, m0_waitrequest} !== 2'b10) begin tests_failed++; $display("FAIL t1_accept: got %b want 10", {s_read, m0_waitrequest}); end
      tests_run++; if (s_address !== 25'h10) begin tests_failed++; $display("FAIL t1_addr: got %h want 10", s_address); end
      step();
      m0_read = 0;
      #1;
      tests_run++; if (pending_out !== 4'd1) begin tests_failed++; $display("FAIL t1_pending1: got %0d want 1", pending_out); end
      step();
      step();
      s_readdata = 16'hBEEF; s_readdatavalid = 1;
      #1;
      tests_run++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin tests_failed++; $display("FAIL t1_rdv: got %b want 10", {m0_readdatavalid, m1_readdatavalid}); end
      tests_run++; if (m0_readdata !== 16'hBEEF) begin tests_failed++; $display("FAIL t1_data: got %h want BEEF", m0_readdata); end
      step();
      s_readdatavalid = 0;
      #1;
      tests_run++; if (pending_out !== 4'd0) begin tests_failed++; $display("FAIL t1_pending0: got %0d want 0", pending_out); end
   endtask

   task automatic test_interleave();
      logic exp_id;
      idle_inputs();
      apply_reset();
      m0_read = 1; m0_address = 25'h100;
      m1_read = 1; m1_address = 25'h200;
      for (int k = 0; k < 8; k++) begin
         if (k == 6) m0_read = 0;
         #1;
         if (k % 2 == 1) begin
            exp_id = (k == 3 || k == 7);
            tests_run++; if (state_out !== {1'b1, exp_id}) begin tests_failed++; $display("FAIL t2_grant k=%0d: got %b want %b", k, state_out, {1'b1, exp_id}); end
            tests_run++; if ({s_read, m0_waitrequest, m1_waitrequest} !== {1'b1, exp_id, ~exp_id}) begin tests_failed++; $display("FAIL t2_accept k=%0d: got %b want %b", k, {s_read, m0_waitrequest, m1_waitrequest}, {1'b1, exp_id, ~exp_id}); end
            tests_run++; if (s_address !== (exp_id ? 25'h200 : 25'h100)) begin tests_failed++; $display("FAIL t2_addr k=%0d: got %h", k, s_address); end
         end else begin
            tests_run++; if (s_read !== 1'b0) begin tests_failed++; $display("FAIL t2_idle k=%0d: got s_read %b want 0", k, s_read); end
         end
         step();
      end
      m1_read = 0;
      #1;
      tests_run++; if (pending_out !== 4'd4) begin tests_failed++; $display("FAIL t2_pending4: got %0d want 4", pending_out); end
      for (int j = 0; j < 4; j++) begin
         s_readdatavalid = 1; s_readdata = 16'hA000 + 16'(j);
         #1;
         exp_id = (j % 2 == 1);
         tests_run++; if ({m0_readdatavalid, m1_readdatavalid} !== {~exp_id, exp_id}) begin tests_failed++; $display("FAIL t2_route j=%0d: got %b want %b", j, {m0_readdatavalid, m1_readdatavalid}, {~exp_id, exp_id}); end
         step();
      end
      s_readdatavalid = 0;
      #1;
      tests_run++; if (pending_out !== 4'd0) begin tests_failed++; $display("FAIL t2_pending0: got %0d want 0", pending_out); end
   endtask

   task automatic test_fifo_full();
      idle_inputs();
      apply_reset();
      m1_read = 1; m1_address = 25'h300;
      for (int k = 0; k < 16; k++) begin
         #1;
         if (k % 2 == 1) begin
            tests_run++; if (m1_waitrequest !== 1'b0) begin tests_failed++; $display("FAIL t3_accept k=%0d: got wait %b want 0", k, m1_waitrequest); end
         end
         step();
      end
      #1;
      tests_run++; if (pending_out !== 4'd8) begin tests_failed++; $display("FAIL t3_pending8: got %0d want 8", pending_out); end
      for (int h = 0; h < 2; h++) begin
         step();
         #1;
         tests_run++; if ({s_read, m1_waitrequest} !== 2'b01) begin tests_failed++; $display("FAIL t3_block h=%0d: got %b want 01", h, {s_read, m1_waitrequest}); end
         tests_run++; if (state_out !== 2'b11) begin tests_failed++; $display("FAIL t3_state h=%0d: got %b want 11", h, state_out); end
      end
      s_readdatavalid = 1;
      #1;
      tests_run++; if ({m1_readdatavalid, s_read, m1_waitrequest} !== 3'b101) begin tests_failed++; $display("FAIL t3_popcycle: got %b want 101", {m1_readdatavalid, s_read, m1_waitrequest}); end
      step();
      s_readdatavalid = 0;
      #1;
      tests_run++; if ({s_read, m1_waitrequest} !== 2'b10) begin tests_failed++; $display("FAIL t3_release: got %b want 10", {s_read, m1_waitrequest}); end
      tests_run++; if (pending_out !== 4'd7) begin tests_failed++; $display("FAIL t3_pending7: got %0d want 7", pending_out); end
      step();
      m1_read = 0;
      #1;
      tests_run++; if (pending_out !== 4'd8) begin tests_failed++; $display("FAIL t3_refill: got %0d want 8", pending_out); end
   endtask

   // Continues from the full FIFO left by test_fifo_full
   task automatic test_write_while_full();
      m0_write = 1; m0_read = 1; m0_address = 25'h20; m0_writedata = 16'h1234; m0_byteenable = 2'b11;
      step();
      #1;
      tests_run++; if ({s_write, s_read, m0_waitrequest} !== 3'b100) begin tests_failed++; $display("FAIL t4_write: got %b want 100", {s_write, s_read, m0_waitrequest}); end
      tests_run++; if ({s_address, s_writedata, s_byteenable} !== {25'h20, 16'h1234, 2'b11}) begin tests_failed++; $display("FAIL t4_wdata: got %h %h %b", s_address, s_writedata, s_byteenable); end
      step();
      m0_write = 0; m0_read = 0;
      #1;
      tests_run++; if (pending_out !== 4'd8) begin tests_failed++; $display("FAIL t4_pending8: got %0d want 8", pending_out); end
      s_readdatavalid = 1;
      #1;
      tests_run++; if (m1_readdatavalid !== 1'b1) begin tests_failed++; $display("FAIL t4_pop: got %b want 1", m1_readdatavalid); end
      step();
      s_readdatavalid = 0; m1_read = 1;
      #1;
      tests_run++; if (pending_out !== 4'd7) begin tests_failed++; $display("FAIL t4_pending7: got %0d want 7", pending_out); end
      step();
      s_readdatavalid = 1;
      #1;
      tests_run++; if ({s_read, m1_waitrequest, m1_readdatavalid} !== 3'b101) begin tests_failed++; $display("FAIL t4_pushpop: got %b want 101", {s_read, m1_waitrequest, m1_readdatavalid}); end
      step();
      s_readdatavalid = 0; m1_read = 0;
      #1;
      tests_run++; if (pending_out !== 4'd7) begin tests_failed++; $display("FAIL t4_count_const: got %0d want 7", pending_out); end
   endtask

   task automatic test_orphan_rdv();
      idle_inputs();
      apply_reset();
      s_readdatavalid = 1;
      #1;
      tests_run++; if ({m0_readdatavalid, m1_readdatavalid, err_out} !== 3'b000) begin tests_failed++; $display("FAIL t5_pulse: got %b want 000", {m0_readdatavalid, m1_readdatavalid, err_out}); end
      step();
      s_readdatavalid = 0;
      #1;
      tests_run++; if (err_out !== 1'b1) begin tests_failed++; $display("FAIL t5_err_set: got %b want 1", err_out); end
      step();
      step();
      tests_run++; if ({err_out, pending_out} !== {1'b1, 4'd0}) begin tests_failed++; $display("FAIL t5_err_sticky: got err %b pending %0d want 1 0", err_out, pending_out); end
   endtask

   task automatic test_reset_midflight();
      idle_inputs();
      apply_reset();
      m0_read = 1; m0_address = 25'h40;
      for (int k = 0; k < 6; k++) step();
      m0_read = 0;
      #1;
      tests_run++; if (pending_out !== 4'd3) begin tests_failed++; $display("FAIL t6_pending3: got %0d want 3", pending_out); end
      apply_reset();
      #1;
      tests_run++; if ({pending_out, state_out} !== 6'b0) begin tests_failed++; $display("FAIL t6_cleared: got pending %0d state %b want 0 00", pending_out, state_out); end
      tests_run++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin tests_failed++; $display("FAIL t6_wait: got %b want 11", {m0_waitrequest, m1_waitrequest}); end
      m0_write = 1; m1_write = 1;
      step();
      #1;
      tests_run++; if ({state_out, m0_waitrequest, m1_waitrequest, s_write} !== 5'b10011) begin tests_failed++; $display("FAIL t6_m0_first: got %b want 10011", {state_out, m0_waitrequest, m1_waitrequest, s_write}); end
      step();
      m0_write = 0; m1_write = 0; s_readdatavalid = 1;
      #1;
      tests_run++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin tests_failed++; $display("FAIL t6_stale_rdv: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
      step();
      s_readdatavalid = 0;
      #1;
      tests_run++; if (err_out !== 1'b1) begin tests_failed++; $display("FAIL t6_stale_err: got %b want 1", err_out); end
   endtask

   initial begin
      reset_n = 0;
      idle_inputs();
      test_reset();
      test_single_read();
      test_interleave();
      test_fifo_full();
      test_write_while_full();
      test_orphan_rdv();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
